// File: rtl/led_blink_driver_pkg.sv
// Shared definitions for the LED blink driver: FSM state encoding,
// default phase timing for the 50 MHz board clock, and a small
// width helper used to size the phase timer.
package led_blink_driver_pkg;

  // 2-bit state encoding shared with anything that decodes the FSM.
  typedef enum logic [1:0] {
    LED_IDLE = 2'd0,
    LED_ON   = 2'd1,
    LED_OFF  = 2'd2
  } led_state_e;

  // Board clock and default blink timing: 0.25 s on, 0.25 s off at 50 MHz.
  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEF_ON_TIME      = CLK_HZ / 4;
  localparam int unsigned DEF_OFF_TIME     = CLK_HZ / 4;
  localparam int unsigned DEF_BLINK_W      = 4;

  // Larger of two phase lengths; the timer must be able to hold either.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_blink_driver_if.sv
// Request/status bundle between the game control logic and the LED driver.
// The control side is the master (issues requests, watches status); the
// driver is the slave (consumes requests, drives the LED and status pulses).
interface led_blink_driver_if #(
  parameter int unsigned BLINK_W = 4
);
  logic               req;       // one-cycle request strobe
  logic [BLINK_W-1:0] n_blinks;  // blink count, meaningful only with req
  logic               led_out;   // LED drive, 1 = lit
  logic               busy;      // a sequence is playing
  logic               done;      // one-cycle pulse at sequence end
  logic               overflow;  // one-cycle pulse when a request is dropped

  modport master (
    output req, n_blinks,
    input  led_out, busy, done, overflow
  );

  modport slave (
    input  req, n_blinks,
    output led_out, busy, done, overflow
  );
endinterface

// File: rtl/led_blink_driver.sv
// Turns request strobes into N blinks of ON_TIME high / OFF_TIME low on the LED pin.
// Latency: LED lights one cycle after an accepted request; all outputs registered.
// Backpressure: none; one request is buffered while playing, a further one is dropped with overflow.
module led_blink_driver
  import led_blink_driver_pkg::*;
#(
  parameter int unsigned ON_TIME  = DEF_ON_TIME,
  parameter int unsigned OFF_TIME = DEF_OFF_TIME,
  parameter int unsigned BLINK_W  = DEF_BLINK_W
) (
  input  logic                    clk,
  input  logic                    reset,
  led_blink_driver_if.slave       bus
);

  localparam int unsigned TMAX = max2(ON_TIME, OFF_TIME);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  // Terminal timer values: a phase lasts timer values 0 .. LAST inclusive.
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TIME - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TIME - 1);

  led_state_e         state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [BLINK_W-1:0] remain_q, remain_d;
  logic               pend_vld_q, pend_vld_d;
  logic [BLINK_W-1:0] pend_cnt_q, pend_cnt_d;
  logic               led_q, busy_q, done_q, ovf_q;
  logic               done_d, ovf_d;

  logic               req_nz;     // request carrying a non-zero count
  logic               req_taken;  // request already used to start a sequence
  logic               pend_free;  // pending slot empty (or emptied this cycle)

  // A zero-count request is ignored everywhere, so qualify it once here.
  assign req_nz = bus.req && (bus.n_blinks != '0);

  // Next-state logic: phase timing, blink counting, pending-slot handling.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    remain_d   = remain_q;
    pend_vld_d = pend_vld_q;
    pend_cnt_d = pend_cnt_q;
    done_d     = 1'b0;
    ovf_d      = 1'b0;
    req_taken  = 1'b0;
    pend_free  = !pend_vld_q;

    case (state_q)
      LED_IDLE: begin
        if (req_nz) begin
          remain_d  = bus.n_blinks;
          timer_d   = '0;
          state_d   = LED_ON;
          req_taken = 1'b1;
        end
      end

      LED_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d  = '0;
          remain_d = remain_q - BLINK_W'(1);
          state_d  = LED_OFF;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      LED_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (remain_q != '0) begin
            state_d = LED_ON;
          end else begin
            done_d = 1'b1;
            if (pend_vld_q) begin
              // Chain the buffered sequence with no idle gap; the slot is
              // free again, so a request arriving now can refill it.
              remain_d   = pend_cnt_q;
              pend_vld_d = 1'b0;
              pend_free  = 1'b1;
              state_d    = LED_ON;
            end else if (req_nz) begin
              // A request landing on the final edge would otherwise be
              // parked in an idle machine; start it directly instead.
              remain_d  = bus.n_blinks;
              state_d   = LED_ON;
              req_taken = 1'b1;
            end else begin
              state_d = LED_IDLE;
            end
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = LED_IDLE;
        timer_d = '0;
      end
    endcase

    // Requests during a sequence go to the one-entry slot; first one wins.
    if ((state_q != LED_IDLE) && req_nz && !req_taken) begin
      if (pend_free) begin
        pend_vld_d = 1'b1;
        pend_cnt_d = bus.n_blinks;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State, counters, pending slot and registered outputs; async reset abandons any sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LED_IDLE;
      timer_q    <= '0;
      remain_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_cnt_q <= '0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      remain_q   <= remain_d;
      pend_vld_q <= pend_vld_d;
      pend_cnt_q <= pend_cnt_d;
      led_q      <= (state_d == LED_ON);
      busy_q     <= (state_d != LED_IDLE);
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver with ON_TIME=3, OFF_TIME=2, BLINK_W=4.
// Reference model tracks each sequence as a position within N*(ON+OFF) cycles.
module tb_led_blink_driver;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int PER = ON + OFF;

  logic clk = 1'b0;
  logic reset = 1'b1;

  led_blink_driver_if #(.BLINK_W(4)) bus();

  led_blink_driver #(
    .ON_TIME (ON),
    .OFF_TIME(OFF),
    .BLINK_W (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_act;
  int m_n;
  int m_pos;
  bit m_pv;
  int m_pc;
  bit m_done;
  bit m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_n = 0; m_pos = 0; m_pv = 0; m_pc = 0; m_done = 0; m_ovf = 0;
  endtask

  // One clock edge of the abstract model with the inputs seen at that edge.
  task automatic model_edge(input logic r, input logic [3:0] n);
    bit rnz;
    rnz = r && (n != 0);
    m_done = 0;
    m_ovf  = 0;
    if (m_act) begin
      m_pos++;
      if (m_pos == m_n * PER) begin
        m_done = 1;
        if (m_pv) begin
          m_n = m_pc; m_pos = 0; m_pv = 0;
          if (rnz) begin m_pv = 1; m_pc = int'(n); end
        end else if (rnz) begin
          m_n = int'(n); m_pos = 0;
        end else begin
          m_act = 0;
        end
      end else if (rnz) begin
        if (!m_pv) begin m_pv = 1; m_pc = int'(n); end
        else m_ovf = 1;
      end
    end else if (rnz) begin
      m_act = 1; m_n = int'(n); m_pos = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".led"},  32'(bus.led_out),  32'(m_act && ((m_pos % PER) < ON)));
    check_val({tag, ".busy"}, 32'(bus.busy),     32'(m_act));
    check_val({tag, ".done"}, 32'(bus.done),     32'(m_done));
    check_val({tag, ".ovf"},  32'(bus.overflow), 32'(m_ovf));
  endtask

  int done_cnt;
  int ovf_cnt;

  // Drive inputs for one edge, advance model, sample 1 time unit after the edge.
  task automatic cycle(input string tag, input logic r, input logic [3:0] n);
    bus.req = r;
    bus.n_blinks = n;
    @(posedge clk);
    model_edge(r, n);
    #1;
    bus.req = 1'b0;
    bus.n_blinks = '0;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.overflow === 1'b1) ovf_cnt++;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int k);
    for (int i = 0; i < k; i++) cycle(tag, 1'b0, 4'd0);
  endtask

  task automatic apply_async_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_val({tag, ".led0"},  32'(bus.led_out),  32'd0);
    check_val({tag, ".busy0"}, 32'(bus.busy),     32'd0);
    check_val({tag, ".done0"}, 32'(bus.done),     32'd0);
    check_val({tag, ".ovf0"},  32'(bus.overflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] exp_led;
    logic [6:0] exp_done;
    exp_led  = 7'b0000111;
    exp_done = 7'b0100000;

    bus.req = 1'b0;
    bus.n_blinks = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b0;

    // Single blink, also against a fixed waveform.
    done_cnt = 0;
    cycle("single", 1'b1, 4'd1);
    check_val("single.led_c1", 32'(bus.led_out), 32'(exp_led[0]));
    for (int k = 2; k <= 7; k++) begin
      cycle("single", 1'b0, 4'd0);
      check_val("single.led_fixed",  32'(bus.led_out), 32'(exp_led[k-1]));
      check_val("single.done_fixed", 32'(bus.done),    32'(exp_done[k-1]));
    end
    idle("single", 2);

    // Multi-blink: exactly one done.
    done_cnt = 0;
    cycle("multi", 1'b1, 4'd3);
    idle("multi", 20);
    check_val("multi.done_count", 32'(done_cnt), 32'd1);

    // Buffered request chains with no gap.
    done_cnt = 0;
    cycle("buf", 1'b1, 4'd2);
    idle("buf", 3);
    cycle("buf", 1'b1, 4'd1);
    idle("buf", 20);
    check_val("buf.done_count", 32'(done_cnt), 32'd2);

    // Overflow: third request dropped.
    done_cnt = 0;
    ovf_cnt  = 0;
    cycle("ovf", 1'b1, 4'd2);
    idle("ovf", 1);
    cycle("ovf", 1'b1, 4'd1);
    idle("ovf", 1);
    cycle("ovf", 1'b1, 4'd5);
    check_val("ovf.pulse", 32'(bus.overflow), 32'd1);
    idle("ovf", 25);
    check_val("ovf.count", 32'(ovf_cnt), 32'd1);
    check_val("ovf.done_count", 32'(done_cnt), 32'd2);

    // Zero count in IDLE is ignored.
    cycle("zero", 1'b1, 4'd0);
    check_val("zero.busy", 32'(bus.busy), 32'd0);
    idle("zero", 3);

    // Async reset mid-ON of a 4-blink sequence, then a clean restart.
    done_cnt = 0;
    cycle("rst", 1'b1, 4'd4);
    idle("rst", 1);
    apply_async_reset("rst");
    idle("rst", 3);
    check_val("rst.no_done", 32'(done_cnt), 32'd0);
    cycle("rst", 1'b1, 4'd4);
    check_val("rst.restart_led", 32'(bus.led_out), 32'd1);
    idle("rst", 25);

    // Randomized traffic, including requests on sequence boundaries and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        apply_async_reset("rand_rst");
      end else if ($urandom_range(0, 5) == 0) begin
        cycle("rand", 1'b1, 4'($urandom_range(0, 4)));
      end else begin
        cycle("rand", 1'b0, 4'($urandom_range(0, 15)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
